// File: rtl/data_memory.sv
// data_memory: word-organised load/store responder with configurable wait states.
// Requests and responses each use a valid/ready handshake; only control state is reset.
module data_memory #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);
    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_rdata;
    logic        r_error;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic          w_access;
    logic          w_err;
    logic [AW-1:0] w_idx;

    assign req_ready  = (r_state == IDLE) && !reset;
    assign resp_valid = (r_state == RESP);
    assign resp_rdata = r_rdata;
    assign resp_error = r_error;
    assign w_accept   = req_valid && req_ready;
    assign w_access   = (r_state == WAIT) && (r_cnt == 4'd0);
    assign w_err      = (r_addr[1:0] != 2'b00) || (r_addr >= ADDR_LIMIT);
    assign w_idx      = r_addr[AW+1:2];

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? WAIT : IDLE;
            WAIT:    w_next = (r_cnt == 4'd0) ? RESP : WAIT;
            RESP:    w_next = resp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_wstrb <= 4'd0;
            r_rdata <= 32'd0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_wstrb <= req_wstrb;
                r_cnt   <= 4'(LATENCY);
            end else if (r_state == WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access) begin
                r_error <= w_err;
                r_rdata <= (w_err || r_write) ? 32'd0 : r_mem[w_idx];
            end
        end
    end

    // Array has no reset so a reset in WAIT simply never reaches the write edge.
    always_ff @(posedge clk) begin
        if (w_access && !w_err && r_write) begin
            for (int k = 0; k < 4; k++) begin
                if (r_wstrb[k]) r_mem[w_idx][8*k +: 8] <= r_wdata[8*k +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: scoreboard bench for data_memory at LATENCY 2 and LATENCY 0.
// Expected responses are queued at issue and checked when each response is consumed.
module tb_data_memory;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        a_req_valid, a_req_ready, a_req_write;
    logic [31:0] a_req_addr, a_req_wdata;
    logic [3:0]  a_req_wstrb;
    logic        a_resp_valid, a_resp_ready, a_resp_error;
    logic [31:0] a_resp_rdata;
    logic        b_req_valid, b_req_ready, b_req_write;
    logic [31:0] b_req_addr, b_req_wdata;
    logic [3:0]  b_req_wstrb;
    logic        b_resp_valid, b_resp_ready, b_resp_error;
    logic [31:0] b_resp_rdata;

    int          vectors = 0;
    int          miscompares = 0;
    logic [32:0] sb_a[$];
    logic [32:0] sb_b[$];
    logic [32:0] ea, eb;
    logic [31:0] bmem[8];

    always #5 clk = ~clk;

    data_memory #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_wstrb(a_req_wstrb),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .resp_error(a_resp_error)
    );

    data_memory #(.DEPTH_WORDS(256), .LATENCY(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_error(b_resp_error)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // An empty queue yields a value no real response can have (error with nonzero data).
    always @(negedge clk) begin
        if (a_resp_valid && a_resp_ready) begin
            ea = (sb_a.size() != 0) ? sb_a.pop_front() : 33'h1_ffff_ffff;
            chk("a_resp", 64'({a_resp_rdata, a_resp_error}), 64'(ea));
        end
        if (b_resp_valid && b_resp_ready) begin
            eb = (sb_b.size() != 0) ? sb_b.pop_front() : 33'h1_ffff_ffff;
            chk("b_resp", 64'({b_resp_rdata, b_resp_error}), 64'(eb));
        end
    end

    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] er, input logic ee,
                       input int hold);
        int n;
        @(negedge clk);
        a_resp_ready = (hold == 0);
        a_req_valid  = 1'b1;
        a_req_write  = w;
        a_req_addr   = a;
        a_req_wdata  = d;
        a_req_wstrb  = s;
        sb_a.push_back({er, ee});
        n = 0;
        while (!a_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("a_accept_wait", 64'(n), 64'(0));
        @(posedge clk);
        #1;
        a_req_valid = (hold > 0);
        a_req_write = 1'($urandom);
        a_req_addr  = $urandom;
        a_req_wdata = $urandom;
        a_req_wstrb = 4'($urandom);
        n = 0;
        while (!a_resp_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("a_latency", 64'(n), 64'(3));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_valid", 64'(a_resp_valid), 64'(1));
            chk("bp_data", 64'({a_resp_rdata, a_resp_error}), 64'({er, ee}));
            chk("bp_req_ready", 64'(a_req_ready), 64'(0));
        end
        if (hold > 0) begin
            @(posedge clk);
            #1;
            a_req_valid  = 1'b0;
            a_resp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("a_ready_back", 64'(a_req_ready), 64'(1));
        chk("a_valid_drop", 64'(a_resp_valid), 64'(0));
        chk("a_sb_empty", 64'(sb_a.size()), 64'(0));
    endtask

    initial begin
        int   n;
        time  tprev, tacc;
        a_req_valid = 0; a_req_write = 0; a_req_addr = 0; a_req_wdata = 0; a_req_wstrb = 0;
        a_resp_ready = 1;
        b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0; b_req_wstrb = 0;
        b_resp_ready = 1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 64'(a_req_ready), 64'(0));
        chk("rst_resp_valid", 64'(a_resp_valid), 64'(0));
        chk("rst_rdata", 64'(a_resp_rdata), 64'(0));
        chk("rst_error", 64'(a_resp_error), 64'(0));
        reset = 1'b0;
        #1;
        chk("rdy_after_rst", 64'(a_req_ready), 64'(1));

        txn(1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0, 0);
        txn(0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 0, 0);
        txn(1, 32'h20, 32'h11223344, 4'hF, 32'h0, 0, 0);
        txn(1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 0, 0);
        txn(0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 0, 0);
        txn(0, 32'h22, 32'h0, 4'hF, 32'h0, 1, 0);
        txn(1, 32'h0, 32'hCAFEF00D, 4'hF, 32'h0, 0, 0);
        txn(1, 32'h400, 32'h0, 4'hF, 32'h0, 1, 0);
        txn(0, 32'h0, 32'h0, 4'hF, 32'hCAFEF00D, 0, 0);
        txn(1, 32'h3FC, 32'h12345678, 4'hF, 32'h0, 0, 0);
        txn(0, 32'h3FC, 32'h0, 4'hF, 32'h12345678, 0, 0);
        txn(1, 32'h10, 32'h0, 4'h0, 32'h0, 0, 0);
        txn(0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 0, 10);

        txn(1, 32'h40, 32'h01020304, 4'hF, 32'h0, 0, 0);
        txn(0, 32'h40, 32'h0, 4'hF, 32'h01020304, 0, 0);
        @(negedge clk);
        a_req_valid = 1; a_req_write = 1; a_req_addr = 32'h40;
        a_req_wdata = 32'h55555555; a_req_wstrb = 4'hF;
        chk("abort_accept", 64'(a_req_ready), 64'(1));
        @(posedge clk);
        #1;
        a_req_valid = 0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_req_ready", 64'(a_req_ready), 64'(0));
        chk("mid_rst_resp_valid", 64'(a_resp_valid), 64'(0));
        chk("mid_rst_rdata", 64'(a_resp_rdata), 64'(0));
        chk("mid_rst_error", 64'(a_resp_error), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rdy_after_mid_rst", 64'(a_req_ready), 64'(1));
        txn(0, 32'h40, 32'h0, 4'hF, 32'h01020304, 0, 0);

        @(negedge clk);
        tprev = 0;
        b_req_valid = 1;
        for (int i = 0; i < 16; i++) begin
            b_req_write = (i < 8);
            b_req_addr  = 32'(4 * (i % 8));
            b_req_wdata = $urandom;
            b_req_wstrb = 4'hF;
            if (i < 8) bmem[i] = b_req_wdata;
            sb_b.push_back((i < 8) ? 33'h0 : {bmem[i-8], 1'b0});
            n = 0;
            while (!b_req_ready && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("b_accept_wait", 64'(n < 20), 64'(1));
            @(posedge clk);
            tacc = $time;
            if (i > 0) chk("b_spacing", 64'(tacc - tprev), 64'(30));
            tprev = tacc;
            #1;
            @(posedge clk);
            #1;
            chk("b_latency", 64'(b_resp_valid), 64'(1));
        end
        b_req_valid = 0;
        repeat (3) @(negedge clk);
        chk("b_sb_empty", 64'(sb_b.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/data_memory.md
# data_memory

Word-organised data memory that acts as the responder on the CPU's load/store port: the `cpu` datapath (or a later LSU) issues requests, and this block accepts them, waits a configurable number of wait states, performs the access and returns a response. It also serves as the bench-side memory model for multi-cycle memory timing. Requests use a valid/ready handshake, and responses use a second valid/ready handshake.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit words. Must be a power of two, 2..65536.
- `LATENCY`, default 2: wait states between acceptance and access, 0..15.
- `clk` in 1: clock, all state changes on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: requester presents a request.
- `req_ready` out 1: block can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, lane-aligned (byte k in bits 8k+7:8k).
- `req_wstrb` in 4: byte enables for stores; ignored for loads.
- `resp_valid` out 1: response available.
- `resp_ready` in 1: requester accepts response.
- `resp_rdata` out 32: load data (full word); 0 for stores and errors.
- `resp_error` out 1: access was misaligned or out of range.

## Operation
- States: IDLE, WAIT, RESP. A 4-bit wait counter is used.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid && req_ready` at an edge, latch write, addr, wdata and wstrb; load the counter with `LATENCY`; go to WAIT.
- WAIT:
  - `req_ready` = 0.
  - At each edge, if the counter ≠ 0, decrement it.
  - If the counter = 0, perform the access, load the response registers and go to RESP.
- Access rules, evaluated on latched values:
  - Error if `addr[1:0]` ≠ 0, or if `addr` ≥ 4·`DEPTH_WORDS`. An error means no memory change, `resp_rdata` = 0, `resp_error` = 1.
  - Word index = `addr[log2(DEPTH_WORDS)+1:2]`.
  - Store: for each k, if `wstrb[k]`, write byte k. `wstrb` = 0000 is a legal no-op with no error. `resp_rdata` = 0.
  - Load: `resp_rdata` = full stored word, sampled after any earlier store has completed. Loads never see a partially written word.
- RESP:
  - `resp_valid` = 1.
  - `resp_rdata` and `resp_error` stay stable until `resp_ready` is sampled high.
  - On that edge, go to IDLE.
- Requests presented outside IDLE are not accepted. `req_*` inputs may change freely after acceptance.
- Memory array contents are not cleared by `reset`, and their simulation start value is undefined. Only control state is reset.

## Timing
- While `reset` = 1: state = IDLE, `req_ready` = 0, `resp_valid` = 0, `resp_rdata` = 0, `resp_error` = 0, counter = 0. These take effect immediately, not at the next edge.
- After `reset` deasserts, `req_ready` = 1 in the same cycle.
- Acceptance at edge E0: access and response registers update at edge E0+`LATENCY`+1. `resp_valid` is high from that edge onward.
- Response consumed at edge Er: `req_ready` = 1 from Er onward. The next acceptance can happen at Er+1 at the earliest.
- Minimum cycles per transaction with `resp_ready` tied high: `LATENCY`+3.
- `resp_ready` held low keeps the block in RESP indefinitely, with outputs unchanged.
- Reset asserted in WAIT: a pending store is aborted and memory is unchanged. Reset asserted in RESP: the response is dropped.
- `req_ready` is a function of state and `reset` only. It has no combinational path from `req_valid`. No output depends combinationally on `resp_ready`.

## Test plan
- Store then load, `LATENCY`=2:
  - Store 0xDEADBEEF to addr 0x10 with wstrb 1111. The store's `resp_valid` rises 3 edges after acceptance, with rdata 0 and error 0.
  - Load 0x10: response rdata 0xDEADBEEF, error 0.
- Byte strobes:
  - Preload 0x11223344 at 0x20.
  - Store 0xAABBCCDD with wstrb 0101.
  - Load 0x20: returns 0x11BB33DD.
- Errors:
  - Load 0x22 (misaligned): error 1, rdata 0.
  - Store to 4·`DEPTH_WORDS`: error 1.
  - Load of the last valid word: unchanged, error 0.
- Backpressure:
  - Hold `resp_ready`=0 for 10 cycles. `resp_valid` stays 1, rdata stays stable, and `req_ready` stays 0 while `req_valid` is held high.
  - Release `resp_ready`: exactly one response is consumed, and `req_ready` returns next cycle.
- Async reset mid-store:
  - Assert `reset` between edges while in WAIT.
  - Outputs go to reset values before the next edge.
  - A later load of that address returns the old data.
- `LATENCY`=0 throughput:
  - Issue 8 back-to-back loads with `resp_ready`=1.
  - Each `resp_valid` comes 1 edge after acceptance.
  - Acceptances are spaced 3 cycles apart.
